// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_WB,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SUBU  = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALU_OUT  = 2'b00;
    localparam logic [1:0] RES_MEM_DATA = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/main_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALU operation class.
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       mem_ready_i,
    output logic       pc_update_o,
    output logic       branch_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_op_o,
    output logic       illegal_o
);

    state_t state, next_state;

    logic unused_funct3;
    assign unused_funct3 = funct3_i[2] ^ funct3_i[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:     if (mem_ready_i) next_state = S_DECODE;
            S_DECODE: begin
                unique case (op_i)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEM_ADR:   next_state = op_i[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready_i) next_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready_i) next_state = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC:
                         next_state = S_ALU_WB;
            S_JALR:      next_state = S_JALR_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JALR_WB, S_TRAP:
                         next_state = S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // Selects follow the state; enables are additionally squashed during reset.
    always_comb begin
        pc_update_o  = 1'b0;
        branch_o     = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_write_o  = 1'b0;
        illegal_o    = 1'b0;
        adr_src_o    = ADR_PC;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        result_src_o = RES_ALU_OUT;
        alu_op_o     = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                ir_write_o   = mem_ready_i;
                pc_update_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEM_ADR, S_JALR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                if (state == S_JALR) begin
                    result_src_o = RES_ALU;
                    pc_update_o  = 1'b1;
                end
            end
            S_MEM_READ:  adr_src_o = ADR_RESULT;
            S_MEM_WRITE: begin
                adr_src_o   = ADR_RESULT;
                mem_write_o = 1'b1;
            end
            S_MEM_WB: begin
                result_src_o = RES_MEM_DATA;
                reg_write_o  = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_FUNCT;
            end
            S_ALU_WB:    reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                branch_o    = 1'b1;
                alu_op_o    = funct3_i[1] ? ALU_SUBU : ALU_SUB;
            end
            S_JAL: begin
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_FOUR;
                pc_update_o = 1'b1;
            end
            S_JALR_WB: begin
                alu_src_a_o  = SRC_A_OLD_PC;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                reg_write_o  = 1'b1;
            end
            S_LUI: begin
                alu_src_a_o = SRC_A_ZERO;
                alu_src_b_o = SRC_B_IMM;
            end
            S_AUIPC: begin
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_IMM;
            end
            S_TRAP:      illegal_o = 1'b1;
            default: ;
        endcase
        if (rst_i) begin
            pc_update_o = 1'b0;
            branch_o    = 1'b0;
            ir_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_write_o = 1'b0;
            illegal_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: each step queues the expected output word,
// then pops and compares it against the DUT on the falling edge.
module tb_main_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       mem_ready_i;
    logic       pc_update_o, branch_o, ir_write_o, reg_write_o, mem_write_o;
    logic       adr_src_o, illegal_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o, alu_op_o;

    int checks = 0;
    int errors = 0;

    logic [14:0] expQueue[$];
    string       tagQueue[$];
    logic [14:0] observed;

    main_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
        .mem_ready_i(mem_ready_i), .pc_update_o(pc_update_o), .branch_o(branch_o),
        .ir_write_o(ir_write_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .adr_src_o(adr_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .result_src_o(result_src_o), .alu_op_o(alu_op_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Word layout: pc,br,ir,rw,mw,adr,A[2],B[2],res[2],op[2],ill
    assign observed = {pc_update_o, branch_o, ir_write_o, reg_write_o, mem_write_o,
                       adr_src_o, alu_src_a_o, alu_src_b_o, result_src_o, alu_op_o,
                       illegal_o};

    localparam logic [14:0] E_FETCH    = {6'b101000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_FETCH_W  = {6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MEM_ADR  = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MEM_READ = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MEM_WB   = {6'b000100, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_MEM_WR   = {6'b000011, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MEM_WR_R = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_EXEC_R   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_EXEC_I   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_ALU_WB   = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_BR_S     = {6'b010000, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_BR_U     = {6'b010000, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0};
    localparam logic [14:0] E_JAL      = {6'b100000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_JALR     = {6'b100000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_JALR_WB  = {6'b000100, 2'b01, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_LUI      = {6'b000000, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_AUIPC    = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_TRAP     = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

    // Drive one cycle's inputs and queue what the outputs should be this cycle.
    task automatic applyStimulus(input logic rst, input logic ready,
                                 input logic [14:0] exp, input string tag);
        rst_i       = rst;
        mem_ready_i = ready;
        expQueue.push_back(exp);
        tagQueue.push_back(tag);
        checkOutput();
        @(posedge clk_i);
        #1;
    endtask

    // Pop the oldest expectation and compare it on the falling edge.
    task automatic checkOutput();
        logic [14:0] exp;
        string tag;
        @(negedge clk_i);
        exp = expQueue.pop_front();
        tag = tagQueue.pop_front();
        checks++;
        assert (observed === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, exp);
        end
    endtask

    task automatic runTwoStep(input logic [6:0] op, input logic [14:0] execExp,
                              input string tag);
        op_i = op;
        applyStimulus(1'b0, 1'b1, E_FETCH, {tag, "_fetch"});
        applyStimulus(1'b0, 1'b1, E_DECODE, {tag, "_decode"});
        applyStimulus(1'b0, 1'b1, execExp, {tag, "_exec"});
        applyStimulus(1'b0, 1'b1, E_ALU_WB, {tag, "_wb"});
    endtask

    initial begin
        rst_i = 1'b1; mem_ready_i = 1'b1; op_i = 7'b0000011; funct3_i = 3'b000;
        @(posedge clk_i);
        #1;
        applyStimulus(1'b1, 1'b1, E_FETCH_W, "reset_hold");

        op_i = 7'b0000011;
        applyStimulus(1'b0, 1'b1, E_FETCH, "lw_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "lw_decode");
        applyStimulus(1'b0, 1'b1, E_MEM_ADR, "lw_memadr");
        applyStimulus(1'b0, 1'b1, E_MEM_READ, "lw_read");
        applyStimulus(1'b0, 1'b1, E_MEM_WB, "lw_wb");

        applyStimulus(1'b0, 1'b0, E_FETCH_W, "lww_fetch_wait1");
        applyStimulus(1'b0, 1'b0, E_FETCH_W, "lww_fetch_wait2");
        applyStimulus(1'b0, 1'b1, E_FETCH, "lww_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "lww_decode");
        applyStimulus(1'b0, 1'b1, E_MEM_ADR, "lww_memadr");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, E_MEM_READ, "lww_read_wait");
        applyStimulus(1'b0, 1'b1, E_MEM_READ, "lww_read");
        applyStimulus(1'b0, 1'b1, E_MEM_WB, "lww_wb");

        op_i = 7'b0100011;
        applyStimulus(1'b0, 1'b1, E_FETCH, "sw_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "sw_decode");
        applyStimulus(1'b0, 1'b1, E_MEM_ADR, "sw_memadr");
        applyStimulus(1'b0, 1'b0, E_MEM_WR, "sw_write_wait");
        applyStimulus(1'b0, 1'b1, E_MEM_WR, "sw_write");

        runTwoStep(7'b0110011, E_EXEC_R, "rtype");
        runTwoStep(7'b0010011, E_EXEC_I, "itype");
        runTwoStep(7'b0110111, E_LUI, "lui");
        runTwoStep(7'b0010111, E_AUIPC, "auipc");
        runTwoStep(7'b1101111, E_JAL, "jal");

        op_i = 7'b1100011; funct3_i = 3'b000;
        applyStimulus(1'b0, 1'b1, E_FETCH, "beq_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "beq_decode");
        applyStimulus(1'b0, 1'b1, E_BR_S, "beq_branch");
        funct3_i = 3'b110;
        applyStimulus(1'b0, 1'b1, E_FETCH, "bltu_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "bltu_decode");
        applyStimulus(1'b0, 1'b1, E_BR_U, "bltu_branch");
        funct3_i = 3'b000;

        op_i = 7'b1100111;
        applyStimulus(1'b0, 1'b1, E_FETCH, "jalr_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "jalr_decode");
        applyStimulus(1'b0, 1'b1, E_JALR, "jalr_exec");
        applyStimulus(1'b0, 1'b1, E_JALR_WB, "jalr_wb");

        op_i = 7'b0000000;
        applyStimulus(1'b0, 1'b1, E_FETCH, "ill_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "ill_decode");
        applyStimulus(1'b0, 1'b1, E_TRAP, "ill_trap");

        op_i = 7'b0100011;
        applyStimulus(1'b0, 1'b1, E_FETCH, "rst_sw_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "rst_sw_decode");
        applyStimulus(1'b0, 1'b1, E_MEM_ADR, "rst_sw_memadr");
        applyStimulus(1'b0, 1'b0, E_MEM_WR, "rst_sw_wait");
        applyStimulus(1'b1, 1'b0, E_MEM_WR_R, "rst_sw_reset");
        applyStimulus(1'b0, 1'b1, E_FETCH, "rst_after_fetch");
        applyStimulus(1'b0, 1'b1, E_DECODE, "rst_after_decode");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
